// File: rtl/tlc_pkg.sv
// Shared types, light codes and phase helpers for the T-junction traffic light controller.
package tlc_pkg;

    typedef logic [2:0] light_t;

    localparam light_t RED    = 3'b100;
    localparam light_t YELLOW = 3'b010;
    localparam light_t GREEN  = 3'b001;

    typedef enum logic [2:0] {
        S1 = 3'd0,
        S2 = 3'd1,
        S3 = 3'd2,
        S4 = 3'd3,
        S5 = 3'd4,
        S6 = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        DUR_MG = 2'd0,
        DUR_Y  = 2'd1,
        DUR_TG = 2'd2,
        DUR_SG = 2'd3
    } dur_sel_t;

    function automatic dur_sel_t dur_sel(input state_t s);
        dur_sel_t sel;
        case (s)
            S1:         sel = DUR_MG;
            S2, S4, S6: sel = DUR_Y;
            S3:         sel = DUR_TG;
            S5:         sel = DUR_SG;
            default:    sel = DUR_MG;
        endcase
        return sel;
    endfunction

    function automatic state_t next_phase(input state_t s);
        state_t nxt;
        case (s)
            S1:      nxt = S2;
            S2:      nxt = S3;
            S3:      nxt = S4;
            S4:      nxt = S5;
            S5:      nxt = S6;
            S6:      nxt = S1;
            default: nxt = S1;
        endcase
        return nxt;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/tlc_sec_tick.sv
// Seconds prescaler: emits a one-cycle tick every CLK_PER_SEC clock cycles.
module tlc_sec_tick
    import tlc_pkg::*;
#(
    parameter int CLK_PER_SEC = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned PW = width_of(CLK_PER_SEC);
    localparam logic [PW-1:0] P_LAST = PW'(CLK_PER_SEC - 1);
    localparam logic [PW-1:0] P_ONE  = PW'(1);

    logic [PW-1:0] r_cnt;

    // Free-running 0..CLK_PER_SEC-1 counter, wrapping in the tick cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_cnt == P_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + P_ONE;
        end
    end

    assign tick = (r_cnt == P_LAST);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Six-phase timed Moore FSM driving four one-hot {R,Y,G} signal heads at a T-junction.
module traffic_light_ctrl
    import tlc_pkg::*;
#(
    parameter int CLK_PER_SEC = 1,
    parameter int T_MG        = 7,
    parameter int T_Y         = 2,
    parameter int T_TG        = 5,
    parameter int T_SG        = 3
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] light_M1,
    output logic [2:0] light_S,
    output logic [2:0] light_M2,
    output logic [2:0] light_MT
);

    localparam int MAX_A   = (T_MG > T_Y) ? T_MG : T_Y;
    localparam int MAX_B   = (T_TG > T_SG) ? T_TG : T_SG;
    localparam int MAX_DUR = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned TW = width_of(MAX_DUR);

    localparam logic [TW-1:0] T_LAST_MG = TW'(T_MG - 1);
    localparam logic [TW-1:0] T_LAST_Y  = TW'(T_Y - 1);
    localparam logic [TW-1:0] T_LAST_TG = TW'(T_TG - 1);
    localparam logic [TW-1:0] T_LAST_SG = TW'(T_SG - 1);
    localparam logic [TW-1:0] T_ONE     = TW'(1);

    logic          w_tick;
    logic          w_phase_end;
    logic [TW-1:0] w_last;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_nxt;
    state_t        r_state;
    state_t        w_state_nxt;
    light_t        w_m1;
    light_t        w_m2;
    light_t        w_mt;
    light_t        w_s;

    tlc_sec_tick #(
        .CLK_PER_SEC (CLK_PER_SEC)
    ) u_sec_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    // Last timer value of the current phase, in seconds minus one.
    always_comb begin
        w_last = T_LAST_MG;
        case (dur_sel(r_state))
            DUR_MG:  w_last = T_LAST_MG;
            DUR_Y:   w_last = T_LAST_Y;
            DUR_TG:  w_last = T_LAST_TG;
            DUR_SG:  w_last = T_LAST_SG;
            default: w_last = T_LAST_MG;
        endcase
    end

    assign w_phase_end = w_tick && (r_timer == w_last);

    // Phase sequencing; unused encodings fall back to S1 with a cleared timer.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        case (r_state)
            S1, S2, S3, S4, S5, S6: begin
                if (w_phase_end) begin
                    w_state_nxt = next_phase(r_state);
                    w_timer_nxt = '0;
                end else if (w_tick) begin
                    w_state_nxt = r_state;
                    w_timer_nxt = r_timer + T_ONE;
                end else begin
                    w_state_nxt = r_state;
                    w_timer_nxt = r_timer;
                end
            end
            default: begin
                w_state_nxt = S1;
                w_timer_nxt = '0;
            end
        endcase
    end

    // State and timer registers; reset wins over a coincident phase end.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S1;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    // Head decode; an illegal state shows all-red.
    always_comb begin
        w_m1 = RED;
        w_m2 = RED;
        w_mt = RED;
        w_s  = RED;
        case (r_state)
            S1: begin w_m1 = GREEN;  w_m2 = GREEN;  w_mt = RED;    w_s = RED;    end
            S2: begin w_m1 = GREEN;  w_m2 = YELLOW; w_mt = RED;    w_s = RED;    end
            S3: begin w_m1 = GREEN;  w_m2 = RED;    w_mt = GREEN;  w_s = RED;    end
            S4: begin w_m1 = YELLOW; w_m2 = RED;    w_mt = YELLOW; w_s = RED;    end
            S5: begin w_m1 = RED;    w_m2 = RED;    w_mt = RED;    w_s = GREEN;  end
            S6: begin w_m1 = RED;    w_m2 = RED;    w_mt = RED;    w_s = YELLOW; end
            default: begin w_m1 = RED; w_m2 = RED; w_mt = RED; w_s = RED; end
        endcase
    end

    assign light_M1 = w_m1;
    assign light_M2 = w_m2;
    assign light_MT = w_mt;
    assign light_S  = w_s;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: two instances (1 and 4 clocks per second) against a period-position model.
module tb_traffic_light_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0] a_m1, a_s, a_m2, a_mt;
    logic [2:0] b_m1, b_s, b_m2, b_mt;

    traffic_light_ctrl #(.CLK_PER_SEC(1)) dut1 (
        .clk(clk), .rst(rst),
        .light_M1(a_m1), .light_S(a_s), .light_M2(a_m2), .light_MT(a_mt)
    );

    traffic_light_ctrl #(.CLK_PER_SEC(4)) dut4 (
        .clk(clk), .rst(rst),
        .light_M1(b_m1), .light_S(b_s), .light_M2(b_m2), .light_MT(b_mt)
    );

    // Phase durations in seconds and head codes {M1,M2,MT,S}, straight from the phase list.
    localparam int DUR [6] = '{7, 2, 5, 2, 3, 2};
    localparam logic [11:0] EXP [6] = '{
        12'b001_001_100_100,
        12'b001_010_100_100,
        12'b001_100_001_100,
        12'b010_100_010_100,
        12'b100_100_100_001,
        12'b100_100_100_010
    };

    int errors = 0;
    int checks = 0;
    int pos1 = 0;
    int pos4 = 0;

    function automatic logic [11:0] expect_lights(input int pos, input int cps);
        int sec;
        logic [11:0] res;
        logic found;
        sec = pos / cps;
        res = 12'b0;
        found = 1'b0;
        for (int p = 0; p < 6; p++) begin
            if (!found && sec < DUR[p]) begin
                res = EXP[p];
                found = 1'b1;
            end else if (!found) begin
                sec = sec - DUR[p];
            end
        end
        return res;
    endfunction

    function automatic logic legal(input logic [2:0] m1, input logic [2:0] m2,
                                   input logic [2:0] mt, input logic [2:0] s);
        logic ok;
        ok = $onehot(m1) && $onehot(m2) && $onehot(mt) && $onehot(s);
        if (s != 3'b100 && !(m1 == 3'b100 && m2 == 3'b100 && mt == 3'b100)) ok = 1'b0;
        if (m2 != 3'b100 && mt != 3'b100) ok = 1'b0;
        return ok;
    endfunction

    task automatic check_heads(input string tag, input logic [2:0] m1, input logic [2:0] m2,
                               input logic [2:0] mt, input logic [2:0] s, input int pos,
                               input int cps);
        logic [11:0] exp_v;
        exp_v = expect_lights(pos, cps);
        checks++;
        assert ({m1, m2, mt, s} === exp_v) else begin
            errors++;
            $error("FAIL %s pos=%0d observed=%b expected=%b", tag, pos, {m1, m2, mt, s}, exp_v);
        end
        checks++;
        assert (legal(m1, m2, mt, s) === 1'b1) else begin
            errors++;
            $error("FAIL %s_invariant pos=%0d observed=%b expected=legal", tag, pos, {m1, m2, mt, s});
        end
    endtask

    // One clock: drive rst, advance the model on the edge, check both instances.
    task automatic step(input logic r);
        rst = r;
        @(posedge clk);
        #1;
        if (r) begin
            pos1 = 0;
            pos4 = 0;
        end else begin
            pos1 = (pos1 + 1) % 21;
            pos4 = (pos4 + 1) % 84;
        end
        check_heads("cps1", a_m1, a_m2, a_mt, a_s, pos1, 1);
        check_heads("cps4", b_m1, b_m2, b_mt, b_s, pos4, 4);
    endtask

    initial begin
        step(1'b1);
        for (int i = 0; i < 100; i++) step(1'b0);

        for (int k = 0; k < 40 && pos1 != 11; k++) step(1'b0);
        step(1'b1);
        for (int i = 0; i < 30; i++) step(1'b0);

        for (int i = 0; i < 10; i++) step(1'b1);
        for (int i = 0; i < 30; i++) step(1'b0);

        for (int i = 0; i < 300; i++) step(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0);

        step(1'b1);
        for (int i = 0; i < 420; i++) step(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
